mem_port_arbiter: RTL and testbench

Sequencing controller that shares one single-ported, fixed-latency memory between the instruction-fetch (IF) stage and the data-memory (MEM) stage of the pipelined CPU. It arbitrates the two request ports, issues one memory access at a time, counts the memory latency, returns read data with a one-cycle done pulse, and drives per-port stall signals that freeze the pipeline while an access is outstanding. It sits between the IF/MEM pipeline stages and the unified memory model.

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 102 ++++++++++
 tb/tb_mem_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Function : IF-fetch, MEM-stage and memory-side signals of mem_port_arbiter
// Revision : 1.0
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          stall_if;
    logic          stall_d;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Requesters plus memory model side
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_done, d_rdata, d_done, stall_if, stall_d,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_done, d_rdata, d_done, stall_if, stall_d,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Function : Shares one fixed-latency memory between IF fetch and MEM stage
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_port_arbiter_if.slave  bus
);
    localparam logic [3:0] c_lat = 4'(MEM_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_grant_d;
    logic          r_last_d;
    logic          r_we;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_d_rdata;
    logic          w_pick_d;
    logic          w_if_done;
    logic          w_d_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant_d  <= 1'b0;
            r_last_d   <= 1'b0;
            r_we       <= 1'b0;
            r_cnt      <= 4'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        r_grant_d <= w_pick_d;
                        r_last_d  <= w_pick_d;
                        r_we      <= w_pick_d & bus.d_we;
                        r_addr    <= w_pick_d ? bus.d_addr : bus.if_addr;
                        r_wdata   <= w_pick_d ? bus.d_wdata : '0;
                    end
                end
                ISSUE: r_cnt <= c_lat;
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    // Data is valid only on the final WAIT cycle
                    if (r_cnt == 4'd1 && !r_we) begin
                        if (r_grant_d) r_d_rdata  <= bus.mem_rdata;
                        else           r_if_rdata <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        // D wins a tie unless it also took the previous grant
        w_pick_d    = bus.d_req & (~bus.if_req | ~r_last_d);
        case (r_state)
            IDLE:    if (bus.if_req || bus.d_req) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = WAIT;
            WAIT:    if (r_cnt == 4'd1) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        w_if_done     = (r_state == RESP) & ~r_grant_d;
        w_d_done      = (r_state == RESP) &  r_grant_d;
        bus.if_done   = w_if_done;
        bus.d_done    = w_d_done;
        bus.if_rdata  = r_if_rdata;
        bus.d_rdata   = r_d_rdata;
        bus.stall_if  = bus.if_req & ~w_if_done;
        bus.stall_d   = bus.d_req & ~w_d_done;
        bus.mem_en    = (r_state == ISSUE);
        bus.mem_we    = (r_state == ISSUE) & r_we;
        bus.mem_addr  = r_addr;
        bus.mem_wdata = r_wdata;
    end
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Function : Scoreboard bench for mem_port_arbiter at MEM_LAT 1, 2 and 4
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus2 ();
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus4 ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory model: backing store plus per-instance latency pipelines
    logic [31:0] store [logic [31:0]];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (store.exists(a)) return store[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    logic [15:0] pv1 = '0, pv2 = '0, pv4 = '0;
    logic [31:0] pd1 [16];
    logic [31:0] pd2 [16];
    logic [31:0] pd4 [16];

    always @(posedge clk) begin
        pv1 <= {pv1[14:0], bus1.mem_en};
        pv2 <= {pv2[14:0], bus2.mem_en};
        pv4 <= {pv4[14:0], bus4.mem_en};
        pd1[0] <= mem_read(bus1.mem_addr);
        pd2[0] <= mem_read(bus2.mem_addr);
        pd4[0] <= mem_read(bus4.mem_addr);
        for (int i = 1; i < 16; i++) begin
            pd1[i] <= pd1[i-1];
            pd2[i] <= pd2[i-1];
            pd4[i] <= pd4[i-1];
        end
    end

    always @(posedge clk) begin
        if (bus2.mem_en && bus2.mem_we) store[bus2.mem_addr] = bus2.mem_wdata;
    end

    // Outside the valid cycle the memory drives a per-cycle junk value
    assign bus1.mem_rdata = pv1[0] ? pd1[0] : (32'hBAD00000 | 32'(cyc));
    assign bus2.mem_rdata = pv2[1] ? pd2[1] : (32'hBAD00000 | 32'(cyc));
    assign bus4.mem_rdata = pv4[3] ? pd4[3] : (32'hBAD00000 | 32'(cyc));

    // Scoreboard for the MEM_LAT=2 instance
    exp_t        sb2 [$];
    exp_t        e;
    logic [31:0] last_d2 = '0;
    logic        prev_en2 = 1'b0;

    always @(negedge clk) begin
        if (!rst && (bus2.if_done || bus2.d_done)) begin
            chk("done_excl", 64'(bus2.if_done & bus2.d_done), 0);
            if (sb2.size() == 0) begin
                chk("done_unexp", 64'(bus2.if_done | bus2.d_done), 0);
            end else begin
                e = sb2.pop_front();
                chk("done_port", 64'(bus2.d_done), 64'(e.is_d));
                chk("done_cyc", 64'(cyc), 64'(e.cyc));
                if (e.is_d) begin
                    if (!e.we) last_d2 = e.data;
                    chk("d_rdata", bus2.d_rdata, last_d2);
                end else begin
                    chk("if_rdata", bus2.if_rdata, e.data);
                end
            end
        end
        if (!rst && bus2.mem_en) chk("en_b2b", 64'(prev_en2), 0);
        prev_en2 = bus2.mem_en;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_if(input int n, input logic [31:0] base);
        bus2.if_req  = 1'b1;
        bus2.if_addr = base;
        for (int k = 0; k < n; k++) begin
            int t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!bus2.if_done && t < 60);
            if (!bus2.if_done) begin
                chk("if_timeout", 64'(bus2.if_done), 1);
                bus2.if_req = 1'b0;
                return;
            end
            step();
            if (k == n - 1) bus2.if_req = 1'b0;
            else            bus2.if_addr = base + 32'(4 * (k + 1));
        end
    endtask

    task automatic run_d(input int n, input logic [31:0] base, input logic we,
                         input logic [31:0] wdata);
        bus2.d_req   = 1'b1;
        bus2.d_we    = we;
        bus2.d_addr  = base;
        bus2.d_wdata = wdata;
        for (int k = 0; k < n; k++) begin
            int t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!bus2.d_done && t < 60);
            if (!bus2.d_done) begin
                chk("d_timeout", 64'(bus2.d_done), 1);
                bus2.d_req = 1'b0;
                return;
            end
            step();
            if (k == n - 1) bus2.d_req = 1'b0;
            else            bus2.d_addr = base + 32'(4 * (k + 1));
        end
    endtask

    initial begin
        int c0;
        store[32'h00003000] = 32'h3C010001;
        {bus1.if_req, bus1.d_req, bus1.d_we} = '0;
        {bus2.if_req, bus2.d_req, bus2.d_we} = '0;
        {bus4.if_req, bus4.d_req, bus4.d_we} = '0;
        bus1.if_addr = '0; bus1.d_addr = '0; bus1.d_wdata = '0;
        bus2.if_addr = '0; bus2.d_addr = '0; bus2.d_wdata = '0;
        bus4.if_addr = '0; bus4.d_addr = '0; bus4.d_wdata = '0;

        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_en",    64'(bus2.mem_en), 0);
        chk("rst_mem_we",    64'(bus2.mem_we), 0);
        chk("rst_mem_addr",  bus2.mem_addr, 0);
        chk("rst_mem_wdata", bus2.mem_wdata, 0);
        chk("rst_if_rdata",  bus2.if_rdata, 0);
        chk("rst_d_rdata",   bus2.d_rdata, 0);
        chk("rst_dones",     64'({bus2.if_done, bus2.d_done}), 0);
        chk("rst_stalls",    64'({bus2.stall_if, bus2.stall_d}), 0);

        // Tie straight out of reset: D first, then IF
        step();
        c0 = cyc;
        sb2.push_back('{1'b1, 1'b0, mem_read(32'h40), c0 + 4});
        sb2.push_back('{1'b0, 1'b0, mem_read(32'h2000), c0 + 9});
        fork
            run_d(1, 32'h40, 1'b0, '0);
            run_if(1, 32'h2000);
        join

        // Data write
        c0 = cyc;
        sb2.push_back('{1'b1, 1'b1, '0, c0 + 4});
        fork
            run_d(1, 32'h10, 1'b1, 32'hDEADBEEF);
            begin
                repeat (2) @(negedge clk);
                chk("wr_mem_en",    64'(bus2.mem_en), 1);
                chk("wr_mem_we",    64'(bus2.mem_we), 1);
                chk("wr_mem_addr",  bus2.mem_addr, 32'h10);
                chk("wr_mem_wdata", bus2.mem_wdata, 32'hDEADBEEF);
            end
        join
        chk("wr_stored", store.exists(32'h10) ? store[32'h10] : 32'h0, 32'hDEADBEEF);

        // Single IF read with stall profile
        c0 = cyc;
        sb2.push_back('{1'b0, 1'b0, 32'h3C010001, c0 + 4});
        fork
            run_if(1, 32'h3000);
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("rd_stall_if", 64'(bus2.stall_if), 1);
                    if (k == 1) begin
                        chk("rd_mem_en",   64'(bus2.mem_en), 1);
                        chk("rd_mem_we",   64'(bus2.mem_we), 0);
                        chk("rd_mem_addr", bus2.mem_addr, 32'h3000);
                    end
                end
                @(negedge clk);
                chk("rd_stall_done", 64'(bus2.stall_if), 0);
            end
        join

        // Fairness: D held for three accesses against continuous IF
        c0 = cyc;
        sb2.push_back('{1'b1, 1'b0, mem_read(32'h100),  c0 + 4});
        sb2.push_back('{1'b0, 1'b0, mem_read(32'h2100), c0 + 9});
        sb2.push_back('{1'b1, 1'b0, mem_read(32'h104),  c0 + 14});
        sb2.push_back('{1'b0, 1'b0, mem_read(32'h2104), c0 + 19});
        sb2.push_back('{1'b1, 1'b0, mem_read(32'h108),  c0 + 24});
        fork
            run_d(3, 32'h100, 1'b0, '0);
            run_if(2, 32'h2100);
            begin
                repeat (9) begin
                    @(negedge clk);
                    chk("fair_stall_if", 64'(bus2.stall_if), 1);
                end
            end
        join

        // Reset during WAIT abandons the access
        bus2.if_req  = 1'b1;
        bus2.if_addr = 32'h3000;
        repeat (3) step();
        rst          = 1'b1;
        bus2.if_req  = 1'b0;
        step();
        rst     = 1'b0;
        last_d2 = '0;
        @(negedge clk);
        chk("mid_mem_en",    64'(bus2.mem_en), 0);
        chk("mid_mem_we",    64'(bus2.mem_we), 0);
        chk("mid_mem_addr",  bus2.mem_addr, 0);
        chk("mid_mem_wdata", bus2.mem_wdata, 0);
        chk("mid_if_rdata",  bus2.if_rdata, 0);
        chk("mid_d_rdata",   bus2.d_rdata, 0);
        chk("mid_dones",     64'({bus2.if_done, bus2.d_done}), 0);
        repeat (4) step();
        c0 = cyc;
        sb2.push_back('{1'b0, 1'b0, 32'h3C010001, c0 + 4});
        run_if(1, 32'h3000);

        // Latency sweep on the MEM_LAT=1 and MEM_LAT=4 instances
        c0 = cyc;
        fork
            begin
                int t = 0;
                bus1.if_req  = 1'b1;
                bus1.if_addr = 32'h400;
                do begin
                    @(negedge clk);
                    t++;
                end while (!bus1.if_done && t < 30);
                chk("lat1_cyc",  64'(cyc - c0), 3);
                chk("lat1_data", bus1.if_rdata, mem_read(32'h400));
                step();
                bus1.if_req = 1'b0;
            end
            begin
                int t = 0;
                bus4.d_req  = 1'b1;
                bus4.d_addr = 32'h500;
                do begin
                    @(negedge clk);
                    t++;
                end while (!bus4.d_done && t < 30);
                chk("lat4_cyc",  64'(cyc - c0), 6);
                chk("lat4_data", bus4.d_rdata, mem_read(32'h500));
                step();
                bus4.d_req = 1'b0;
            end
        join

        repeat (5) step();
        chk("sb_left", 64'(sb2.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
